// File: rtl/clap_light_controller.sv
// Clap-driven light controller: toggles the LED bank on a matching clap count,
// with a post-toggle lockout window and an optional auto-off timer.
module clap_light_controller #(
  parameter int unsigned SUC_CLAPS_WIDTH = 16,
  parameter int unsigned TOGGLE_CLAPS    = 2,
  parameter int unsigned LOCKOUT_CYCLES  = 50000000,
  parameter int unsigned AUTO_OFF_CYCLES = 0,
  parameter int unsigned LED_WIDTH       = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [SUC_CLAPS_WIDTH-1:0] suc_claps_data,
  input  logic                       suc_claps_valid,
  output logic                       suc_claps_ready,
  output logic [LED_WIDTH-1:0]       led,
  output logic                       light_on,
  output logic                       toggle_pulse,
  output logic [SUC_CLAPS_WIDTH-1:0] last_claps,
  output logic                       lockout_active
);

  localparam int unsigned LockW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int unsigned OffW  = (AUTO_OFF_CYCLES > 1) ? $clog2(AUTO_OFF_CYCLES) : 1;

  localparam logic [LockW-1:0] LockReload =
      LockW'((LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0);
  localparam logic [OffW-1:0] OffLast =
      OffW'((AUTO_OFF_CYCLES > 0) ? AUTO_OFF_CYCLES - 1 : 0);
  localparam logic [SUC_CLAPS_WIDTH-1:0] ToggleVal = SUC_CLAPS_WIDTH'(TOGGLE_CLAPS);

  typedef enum logic [0:0] {StReady, StLockout} state_e;

  state_e                     state_q, state_d;
  logic [LockW-1:0]           lock_cnt_q, lock_cnt_d;
  logic [OffW-1:0]            off_cnt_q, off_cnt_d;
  logic                       light_q, light_d;
  logic                       pulse_q, pulse_d;
  logic                       ready_q;
  logic [SUC_CLAPS_WIDTH-1:0] last_q, last_d;

  logic accept;
  logic toggle_req;
  logic auto_fire;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    off_cnt_d  = '0;
    light_d    = light_q;
    pulse_d    = 1'b0;
    last_d     = last_q;

    accept     = suc_claps_valid && ready_q;
    toggle_req = accept && (suc_claps_data == ToggleVal) && (state_q == StReady);
    auto_fire  = (AUTO_OFF_CYCLES > 0) && light_q && (off_cnt_q == OffLast);

    if (accept) begin
      last_d = suc_claps_data;
    end

    unique case (state_q)
      StReady: begin
        if (toggle_req && (LOCKOUT_CYCLES > 0)) begin
          state_d    = StLockout;
          lock_cnt_d = LockReload;
        end
      end
      StLockout: begin
        if (lock_cnt_q == '0) begin
          state_d = StReady;
        end else begin
          lock_cnt_d = lock_cnt_q - LockW'(1);
        end
      end
      default: state_d = StReady;
    endcase

    // Auto-off wins over a coincident toggle so the edge never double-toggles.
    if (auto_fire) begin
      light_d = 1'b0;
    end else if (toggle_req) begin
      light_d = !light_q;
    end

    pulse_d = (light_d != light_q);

    if ((AUTO_OFF_CYCLES > 0) && light_q && !pulse_d) begin
      off_cnt_d = off_cnt_q + OffW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StReady;
      lock_cnt_q <= '0;
      off_cnt_q  <= '0;
      light_q    <= 1'b0;
      pulse_q    <= 1'b0;
      ready_q    <= 1'b0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      off_cnt_q  <= off_cnt_d;
      light_q    <= light_d;
      pulse_q    <= pulse_d;
      ready_q    <= 1'b1;
      last_q     <= last_d;
    end
  end

  assign suc_claps_ready = ready_q;
  assign led             = {LED_WIDTH{light_q}};
  assign light_on        = light_q;
  assign toggle_pulse    = pulse_q;
  assign last_claps      = last_q;
  assign lockout_active  = (state_q == StLockout);

endmodule

// File: tb/tb_clap_light_controller.sv
// Bench for clap_light_controller: two configurations (lockout 4 / auto-off 20, and
// no lockout / no auto-off) checked every cycle against a timestamp-based model.
module tb_clap_light_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] data  = '0;

  logic        a_ready, a_light, a_pulse, a_lock;
  logic [7:0]  a_led;
  logic [15:0] a_last;
  logic        b_ready, b_light, b_pulse, b_lock;
  logic [7:0]  b_led;
  logic [15:0] b_last;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  clap_light_controller #(
    .SUC_CLAPS_WIDTH(16), .TOGGLE_CLAPS(2), .LOCKOUT_CYCLES(4), .AUTO_OFF_CYCLES(20),
    .LED_WIDTH(8)
  ) dut_a (
    .clock(clock), .reset(reset), .suc_claps_data(data), .suc_claps_valid(valid),
    .suc_claps_ready(a_ready), .led(a_led), .light_on(a_light), .toggle_pulse(a_pulse),
    .last_claps(a_last), .lockout_active(a_lock)
  );

  clap_light_controller #(
    .SUC_CLAPS_WIDTH(16), .TOGGLE_CLAPS(2), .LOCKOUT_CYCLES(0), .AUTO_OFF_CYCLES(0),
    .LED_WIDTH(8)
  ) dut_b (
    .clock(clock), .reset(reset), .suc_claps_data(data), .suc_claps_valid(valid),
    .suc_claps_ready(b_ready), .led(b_led), .light_on(b_light), .toggle_pulse(b_pulse),
    .last_claps(b_last), .lockout_active(b_lock)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: lockout and auto-off tracked as edge timestamps rather than counters.
  longint p_lock[2] = '{4, 0};
  longint p_auto[2] = '{20, 0};
  longint edge_n = 0;
  bit     started = 0;
  bit          m_ready[2];
  bit          m_light[2];
  bit          m_pulse[2];
  bit          m_lock[2];
  logic [15:0] m_last[2];
  longint      m_lock_end[2];
  longint      m_on_since[2];

  task automatic model_step(input int k);
    bit acc, pre_lock, fire, tog, nl;
    if (reset) begin
      m_ready[k] = 0; m_light[k] = 0; m_pulse[k] = 0; m_lock[k] = 0;
      m_last[k] = '0; m_lock_end[k] = edge_n - 1; m_on_since[k] = edge_n;
    end else begin
      acc      = valid && m_ready[k];
      pre_lock = (edge_n <= m_lock_end[k]);
      fire     = (p_auto[k] > 0) && m_light[k] && (edge_n - m_on_since[k] == p_auto[k]);
      tog      = acc && (data == 16'd2) && !pre_lock;
      nl       = m_light[k];
      if (fire) nl = 0;
      else if (tog) nl = !nl;
      if (tog) m_lock_end[k] = edge_n + p_lock[k];
      if (nl && !m_light[k]) m_on_since[k] = edge_n;
      m_pulse[k] = (nl != m_light[k]);
      m_light[k] = nl;
      if (acc) m_last[k] = data;
      m_ready[k] = 1;
      m_lock[k]  = (edge_n < m_lock_end[k]);
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      edge_n++;
      if (reset) started = 1;
      model_step(0);
      model_step(1);
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (started) begin
        check("a_ready", a_ready, m_ready[0]);
        check("a_light", a_light, m_light[0]);
        check("a_led",   a_led,   {8{m_light[0]}});
        check("a_pulse", a_pulse, m_pulse[0]);
        check("a_last",  a_last,  m_last[0]);
        check("a_lock",  a_lock,  m_lock[0]);
        check("b_ready", b_ready, m_ready[1]);
        check("b_light", b_light, m_light[1]);
        check("b_led",   b_led,   {8{m_light[1]}});
        check("b_pulse", b_pulse, m_pulse[1]);
        check("b_last",  b_last,  m_last[1]);
        check("b_lock",  b_lock,  m_lock[1]);
      end
    end
  end

  task automatic send(input logic [15:0] v);
    valid = 1'b1;
    data  = v;
    @(negedge clock);
    valid = 1'b0;
  endtask

  initial begin
    int n;
    int r;
    // Reset held 3 cycles.
    repeat (3) begin
      @(negedge clock);
      check("rst_ready", a_ready, 0);
      check("rst_led", a_led, 0);
      check("rst_lock", a_lock, 0);
    end
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_rst", a_ready, 1);

    // First toggle, then a toggle count inside lockout.
    send(16'd2);
    check("t2_light", a_light, 1);
    check("t2_led", a_led, 8'hFF);
    check("t2_pulse", a_pulse, 1);
    check("t2_lock", a_lock, 1);
    check("t2_last", a_last, 16'd2);
    send(16'd2);
    check("t3_light_held", a_light, 1);
    check("t3_no_pulse", a_pulse, 0);
    check("t3_last", a_last, 16'd2);
    repeat (2) @(negedge clock);
    check("t2_lock_4th", a_lock, 1);
    @(negedge clock);
    check("t2_lock_end", a_lock, 0);
    send(16'd2);
    check("t3_light_off", a_light, 0);
    check("t3_pulse", a_pulse, 1);

    // Non-toggle counts in READY.
    repeat (5) @(negedge clock);
    send(16'd1);
    check("t4_last1", a_last, 16'd1);
    send(16'd3);
    check("t4_last3", a_last, 16'd3);
    send(16'd0);
    check("t4_last0", a_last, 16'd0);
    check("t4_light", a_light, 0);
    check("t4_pulse", a_pulse, 0);

    // Auto-off after 20 cycles.
    send(16'd2);
    n = 41;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (!a_light) begin
        n = i;
        break;
      end
    end
    check("t5_auto_off_delay", n, 20);
    check("t5_auto_pulse", a_pulse, 1);

    // Toggle count landing on the auto-off edge.
    send(16'd2);
    repeat (19) @(negedge clock);
    valid = 1'b1;
    data  = 16'd2;
    @(negedge clock);
    valid = 1'b0;
    check("t5_coinc_light", a_light, 0);
    check("t5_coinc_pulse", a_pulse, 1);
    check("t5_coinc_lock", a_lock, 1);
    @(negedge clock);
    check("t5_coinc_single", a_pulse, 0);

    // Reset mid-lockout with the light on.
    repeat (5) @(negedge clock);
    send(16'd2);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t6_light", a_light, 0);
    check("t6_lock", a_lock, 0);
    check("t6_ready", a_ready, 0);
    @(negedge clock);
    valid = 1'b1;
    data  = 16'd2;
    @(negedge clock);
    check("t6_b_on", b_light, 1);
    check("t6_b_pulse_on", b_pulse, 1);
    @(negedge clock);
    valid = 1'b0;
    check("t6_b_off", b_light, 0);
    check("t6_b_pulse_off", b_pulse, 1);

    // Randomized traffic, alternating busy and quiet phases.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 499) == 0);
      if (((i / 500) % 2) == 0) valid = ($urandom_range(0, 1) == 1);
      else valid = ($urandom_range(0, 39) == 0);
      r = $urandom_range(0, 9);
      if (r < 5) data = 16'd2;
      else if (r == 5) data = 16'd0;
      else if (r == 6) data = 16'h8002;
      else if (r == 7) data = 16'($urandom_range(0, 5));
      else data = 16'($urandom);
    end
    @(negedge clock);
    reset = 1'b0;
    valid = 1'b0;
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
